// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: widths and the
// write-back request record carried from the write-back stage into the queue.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Register 0 is hard-wired; requests aimed at it are swallowed.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_onehot_dec.sv
// Address-to-one-hot decoder driving the per-register write enables.
// Output is all zeros unless i_en is set.
module regfile_onehot_dec
  import regfile_pkg::*;
(
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  // Single bit set at the addressed register, gated by the enable.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back buffer in front of the 32 x 32 register array.
// Requests enter through valid/ready, are held in a DEPTH-entry circular
// queue and commit one per cycle from the head when drain_en allows.
// A lookup port forwards the youngest queued value for a register that has
// not been committed yet. Writes to register 0 are accepted and dropped.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  input  logic                     drain_en,
  output logic                     regWrite,
  output logic [NUM_REGS-1:0]      en,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  wb_req_t          w_in_req;
  wb_req_t          w_head_req;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_in_req.addr = in_addr;
  assign w_in_req.data = in_data;
  assign w_head_req    = r_mem[r_head];

  // Handshake and commit qualification; flush wins over both push and pop.
  // in_ready is left ungated by flush so it always reflects occupancy.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept = in_valid && in_ready && !flush;
  assign w_push   = w_accept && !is_zero_reg(in_addr);
  assign w_pop    = !w_empty && drain_en && !flush;

  assign regWrite  = w_pop;
  assign writeData = w_head_req.data;
  assign count     = r_count;

  regfile_onehot_dec u_dec (
    .i_en     (w_pop),
    .i_addr   (w_head_req.addr),
    .o_onehot (en)
  );

  // Queue storage, pointers and occupancy; flush clears pointers but keeps
  // storage so writeData still shows the stale head slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_in_req;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  // The head is included even in the cycle it commits.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (!is_zero_reg(fwd_addr)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < r_count) &&
            (r_mem[r_head + PTR_W'(i)].addr == fwd_addr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_mem[r_head + PTR_W'(i)].data;
        end
      end
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: stimulus pushes the expected
// commit for every enqueued request; a negedge monitor pops and compares on
// each regWrite strobe. Directed checks cover occupancy, forwarding, flush
// and asynchronous reset.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   flush;
  logic                   drain_en;
  logic                   regWrite;
  logic [NUM_REGS-1:0]    en;
  logic [DATA_W-1:0]      writeData;
  logic [ADDR_W-1:0]      fwd_addr;
  logic                   fwd_hit;
  logic [DATA_W-1:0]      fwd_data;
  logic [$clog2(DEPTH):0] count;

  int n_tests = 0;
  int n_fail  = 0;

  wb_req_t sb[$];

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .flush     (flush),
    .drain_en  (drain_en),
    .regWrite  (regWrite),
    .en        (en),
    .writeData (writeData),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Monitor: every commit must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset) begin
      if (regWrite) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", 64'(en), 64'd0);
        end else begin
          wb_req_t e;
          e = sb.pop_front();
          check("commit_en", 64'(en), 64'(onehot(e.addr)));
          check("commit_data", 64'(writeData), 64'(e.data));
        end
      end else begin
        check("idle_en", 64'(en), 64'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after the next one.
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic exp_ready);
    wb_req_t r;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    check("push_in_ready", 64'(in_ready), 64'(exp_ready));
    @(posedge clk);
    if (exp_ready && (a != '0)) begin
      r.addr = a;
      r.data = d;
      sb.push_back(r);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    in_addr  = 5'd5;
    in_data  = 32'hCAFE_F00D;
    flush    = 1'b0;
    drain_en = 1'b1;
    fwd_addr = 5'd5;

    // Reset with in_valid asserted
    #12;
    check("rst_regWrite", 64'(regWrite), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    check("rst_writeData", 64'(writeData), 64'd0);
    check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    check("rst_fwd_data", 64'(fwd_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single write: commits the next cycle
    push(5'd5, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("t1_count_n1", 64'(count), 64'd1);
    check("t1_regWrite", 64'(regWrite), 64'd1);
    check("t1_en", 64'(en), 64'h0000_0020);
    check("t1_fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_count_after", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Fill to full, reject fifth, then drain in order
    drain_en = 1'b0;
    push(5'd1, 32'h0000_0101, 1'b1);
    push(5'd2, 32'h0000_0102, 1'b1);
    push(5'd3, 32'h0000_0103, 1'b1);
    push(5'd4, 32'h0000_0104, 1'b1);
    @(negedge clk);
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    push(5'd6, 32'h0000_0106, 1'b0);
    check("t2_count_after_reject", 64'(count), 64'd4);
    drain_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_in_ready_after_pop", 64'(in_ready), 64'd1);
    check("t2_count_after_pop", 64'(count), 64'd3);
    idle(4);
    check("t2_count_drained", 64'(count), 64'd0);

    // Zero register: handshake completes, nothing queued
    push(5'd0, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check("t3_count_zero", 64'(count), 64'd0);
    idle(3);

    // Forwarding picks the youngest match
    drain_en = 1'b0;
    push(5'd7, 32'h0000_0011, 1'b1);
    push(5'd7, 32'h0000_0022, 1'b1);
    fwd_addr = 5'd7;
    #1;
    check("t4_fwd_hit", 64'(fwd_hit), 64'd1);
    check("t4_fwd_data", 64'(fwd_data), 64'h22);
    fwd_addr = 5'd0;
    #1;
    check("t4_fwd0_hit", 64'(fwd_hit), 64'd0);
    check("t4_fwd0_data", 64'(fwd_data), 64'd0);
    fwd_addr = 5'd8;
    #1;
    check("t4_fwd_miss", 64'(fwd_hit), 64'd0);
    fwd_addr = 5'd7;
    drain_en = 1'b1;
    @(posedge clk); #1;
    check("t4_fwd_after_pop", 64'(fwd_data), 64'h22);
    idle(3);
    check("t4_fwd_drained", 64'(fwd_hit), 64'd0);

    // Flush with a concurrent push
    drain_en = 1'b0;
    push(5'd10, 32'h0000_0A0A, 1'b1);
    push(5'd11, 32'h0000_0B0B, 1'b1);
    push(5'd12, 32'h0000_0C0C, 1'b1);
    flush    = 1'b1;
    drain_en = 1'b1;
    in_valid = 1'b1;
    in_addr  = 5'd13;
    in_data  = 32'h0000_0D0D;
    @(negedge clk);
    check("t5_flush_regWrite", 64'(regWrite), 64'd0);
    check("t5_flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.delete();
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_count_after_flush", 64'(count), 64'd0);
    idle(3);

    // Asynchronous reset while a commit is pending
    drain_en = 1'b0;
    push(5'd9, 32'h0000_0909, 1'b1);
    fwd_addr = 5'd9;
    drain_en = 1'b1;
    #1;
    check("t6_pending_regWrite", 64'(regWrite), 64'd1);
    check("t6_pending_en", 64'(en), 64'(onehot(5'd9)));
    reset = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_regWrite", 64'(regWrite), 64'd0);
    check("t6_rst_en", 64'(en), 64'd0);
    check("t6_rst_writeData", 64'(writeData), 64'd0);
    check("t6_rst_fwd_hit", 64'(fwd_hit), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    check("t6_count_after_release", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream with drain enabled
    push(5'd20, 32'h1111_0000, 1'b1);
    push(5'd21, 32'h2222_0000, 1'b1);
    push(5'd22, 32'h3333_0000, 1'b1);
    idle(4);
    check("end_scoreboard_empty", 64'(sb.size()), 64'd0);
    check("end_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
